// File: rtl/mda_adc_ltc2308_spi_if.sv
// Sequencer handshake plus LTC2308 serial pins for the depth-sensor ADC engine.
// The slave modport is the conversion engine; the master modport is its environment.
interface mda_adc_ltc2308_spi_if;
  logic        measure_start;
  logic [2:0]  measure_ch;
  logic        measure_done;
  logic [11:0] measure_dataread;
  logic        ADC_CONVST;
  logic        ADC_SCK;
  logic        ADC_SDI;
  logic        ADC_SDO;

  modport slave (
    input  measure_start,
    input  measure_ch,
    input  ADC_SDO,
    output measure_done,
    output measure_dataread,
    output ADC_CONVST,
    output ADC_SCK,
    output ADC_SDI
  );

  modport master (
    output measure_start,
    output measure_ch,
    output ADC_SDO,
    input  measure_done,
    input  measure_dataread,
    input  ADC_CONVST,
    input  ADC_SCK,
    input  ADC_SDI
  );
endinterface

// File: rtl/mda_adc_ltc2308_spi.sv
// LTC2308 conversion engine: CONVST pulse, conversion wait, then a 12-pulse SPI
// exchange sending the 6-bit channel config while capturing the 12-bit result.
module mda_adc_ltc2308_spi #(
  parameter int CLK_DIV       = 1,
  parameter int CONVST_CYCLES = 2,
  parameter int CONV_CYCLES   = 64
) (
  input  logic                      adc_clk,
  input  logic                      adc_reset_n,
  mda_adc_ltc2308_spi_if.slave      bus
);

  localparam int DATA_W = 12;
  localparam int CFG_W  = 6;

  localparam logic [7:0] CONVST_LAST = 8'(CONVST_CYCLES - 1);
  localparam logic [7:0] CONV_LAST   = 8'(CONV_CYCLES - 1);
  localparam logic [7:0] DIV_LAST    = 8'(CLK_DIV - 1);
  localparam logic [3:0] LAST_PULSE  = 4'(DATA_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVST,
    ST_CONV_WAIT,
    ST_SHIFT
  } state_t;

  // Single-ended, unipolar, no sleep; channel bits are ordered odd/sign, S1, S0.
  function automatic logic [CFG_W-1:0] cfg_word(input logic [2:0] ch);
    return {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
  endfunction

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [3:0]          rise_q, rise_d;
  logic                convst_q, convst_d;
  logic                sck_q, sck_d;
  logic                sdi_q, sdi_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                done_q, done_d;
  logic                prev_start_q, prev_start_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CFG_W-1:0]    cfg_q, cfg_d;
  logic                start_edge;

  assign start_edge = bus.measure_start & ~prev_start_q;

  // Control and visible outputs; prev_start resets high so a start held through
  // reset release is not mistaken for a fresh request.
  always_ff @(posedge adc_clk) begin
    if (!adc_reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rise_q       <= '0;
      convst_q     <= 1'b0;
      sck_q        <= 1'b0;
      sdi_q        <= 1'b0;
      data_q       <= '0;
      done_q       <= 1'b0;
      prev_start_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rise_q       <= rise_d;
      convst_q     <= convst_d;
      sck_q        <= sck_d;
      sdi_q        <= sdi_d;
      data_q       <= data_d;
      done_q       <= done_d;
      prev_start_q <= prev_start_d;
    end
  end

  always_ff @(posedge adc_clk) begin
    shift_q <= shift_d;
    cfg_q   <= cfg_d;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rise_d       = rise_q;
    convst_d     = convst_q;
    sck_d        = sck_q;
    sdi_d        = sdi_q;
    data_d       = data_q;
    done_d       = done_q;
    shift_d      = shift_q;
    cfg_d        = cfg_q;
    prev_start_d = bus.measure_start;

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          convst_d = 1'b1;
          done_d   = 1'b0;
          cfg_d    = cfg_word(bus.measure_ch);
          cnt_d    = '0;
          state_d  = ST_CONVST;
        end
      end

      ST_CONVST: begin
        if (cnt_q == CONVST_LAST) begin
          convst_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_CONV_WAIT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_CONV_WAIT: begin
        if (cnt_q == CONV_LAST) begin
          sdi_d   = cfg_q[CFG_W-1];
          cnt_d   = '0;
          rise_d  = '0;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          sck_d = ~sck_q;
          if (!sck_q) begin
            // SDO has been settled for a full low half-period at this edge.
            rise_d  = rise_q + 4'd1;
            shift_d = {shift_q[DATA_W-2:0], bus.ADC_SDO};
          end else if (rise_q == LAST_PULSE) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            sdi_d   = 1'b0;
            state_d = ST_IDLE;
          end else begin
            // Config shifts out MSB first; zero fill drives SDI low after bit 0.
            cfg_d = {cfg_q[CFG_W-2:0], 1'b0};
            sdi_d = cfg_q[CFG_W-2];
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Masking done with start keeps a stale result from pairing with a new request.
  assign bus.measure_done     = done_q & ~bus.measure_start;
  assign bus.measure_dataread = data_q;
  assign bus.ADC_CONVST       = convst_q;
  assign bus.ADC_SCK          = sck_q;
  assign bus.ADC_SDI          = sdi_q;

endmodule
